// File: rtl/wwl_driver_if.sv
`default_nettype none
// ============================================================================
// wwl_driver_if : request/word-line bundle between a write controller and
//                 wwl_driver. Rev 1.0
// ============================================================================
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 3
`endif

interface wwl_driver_if;
   logic                        req_valid;
   logic [`ADDR_WIDTH-1:0]      req_addr;
   logic                        req_ready;
   logic [2**`ADDR_WIDTH-1:0]   wwl;
   logic                        busy;
   logic                        done;

   modport master (
      output req_valid, req_addr,
      input  req_ready, wwl, busy, done
   );

   modport slave (
      input  req_valid, req_addr,
      output req_ready, wwl, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/wwl_driver.sv
`default_nettype none
// ============================================================================
// wwl_driver : one-hot write word-line pulse generator with enforced gap.
//              Optional one-entry request buffer via macro WWL_QUEUE_EN.
// Rev 1.0
// ============================================================================
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 3
`endif

module wwl_driver #(
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 1
) (
   input  wire logic    clk,
   input  wire logic    rst,
   wwl_driver_if.slave  bus
);

   localparam int c_AW = `ADDR_WIDTH;
   localparam int c_WL = 2**`ADDR_WIDTH;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PULSE = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   localparam logic [3:0]      c_PULSE_LOAD = 4'(PULSE_CYCLES - 1);
   localparam logic [3:0]      c_GAP_LOAD   = 4'(GAP_CYCLES - 1);
   localparam logic [c_WL-1:0] c_ONE        = c_WL'(1);

   logic [1:0]      r_state, w_state_nxt;
   logic [3:0]      r_cnt, w_cnt_nxt;
   logic [c_WL-1:0] r_wwl, w_wwl_nxt;
   logic            r_done, w_done_nxt;
   logic            w_accept;
   logic            w_ready;
   logic            w_issue;
   logic [c_AW-1:0] w_issue_addr;

`ifdef WWL_QUEUE_EN
   logic            r_q_valid, w_q_valid_nxt;
   logic [c_AW-1:0] r_q_addr, w_q_addr_nxt;
   logic            w_issue_q;
   logic            w_take_req;
`endif

   assign w_accept = bus.req_valid && w_ready;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_wwl   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_wwl   <= w_wwl_nxt;
         r_done  <= w_done_nxt;
      end
   end

`ifdef WWL_QUEUE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q_valid <= 1'b0;
         r_q_addr  <= '0;
      end else begin
         r_q_valid <= w_q_valid_nxt;
         r_q_addr  <= w_q_addr_nxt;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_issue      = 1'b0;
      w_issue_addr = bus.req_addr;
`ifdef WWL_QUEUE_EN
      w_issue_q    = 1'b0;
      w_take_req   = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_PULSE;
               w_issue     = 1'b1;
`ifdef WWL_QUEUE_EN
               w_take_req  = 1'b1;
`endif
            end
         end
         S_PULSE: begin
            if (r_cnt == 4'd0) w_state_nxt = S_GAP;
         end
         S_GAP: begin
            if (r_cnt == 4'd0) begin
`ifdef WWL_QUEUE_EN
               // A buffered or same-edge request chains straight into PULSE.
               if (r_q_valid) begin
                  w_state_nxt  = S_PULSE;
                  w_issue      = 1'b1;
                  w_issue_q    = 1'b1;
                  w_issue_addr = r_q_addr;
               end else if (w_accept) begin
                  w_state_nxt  = S_PULSE;
                  w_issue      = 1'b1;
                  w_take_req   = 1'b1;
               end else begin
                  w_state_nxt  = S_IDLE;
               end
`else
               w_state_nxt = S_IDLE;
`endif
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output / datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_wwl_nxt  = r_wwl;
      w_done_nxt = 1'b0;
      if (w_issue) begin
         w_cnt_nxt = c_PULSE_LOAD;
         w_wwl_nxt = c_ONE << w_issue_addr;
      end else begin
         case (r_state)
            S_PULSE: begin
               if (r_cnt == 4'd0) begin
                  w_cnt_nxt  = c_GAP_LOAD;
                  w_wwl_nxt  = '0;
                  w_done_nxt = 1'b1;
               end else begin
                  w_cnt_nxt  = r_cnt - 4'd1;
               end
            end
            S_GAP: begin
               w_wwl_nxt = '0;
               w_cnt_nxt = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
            end
            default: begin
               w_cnt_nxt = 4'd0;
               w_wwl_nxt = '0;
            end
         endcase
      end
   end

`ifdef WWL_QUEUE_EN
   always_comb begin
      w_q_valid_nxt = (r_q_valid && !w_issue_q) || (w_accept && !w_take_req);
      w_q_addr_nxt  = (w_accept && !w_take_req) ? bus.req_addr : r_q_addr;
   end
   assign w_ready = !rst && !r_q_valid;
`else
   assign w_ready = !rst && (r_state == S_IDLE);
`endif

   assign bus.req_ready = w_ready;
   assign bus.wwl       = r_wwl;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_wwl_driver.sv
`default_nettype none
// ============================================================================
// tb_wwl_driver : directed, table-driven self-checking bench for wwl_driver.
// Rev 1.0
// ============================================================================
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 3
`endif

module tb_wwl_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wwl_driver_if if_a ();
   wwl_driver_if if_b ();

   wwl_driver #(.PULSE_CYCLES(2), .GAP_CYCLES(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a.slave)
   );

   wwl_driver #(.PULSE_CYCLES(1), .GAP_CYCLES(3)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b.slave)
   );

   typedef struct {
      logic [2:0] addr;
      logic [7:0] exp_wwl;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   // Invariant on every cycle: one-hot-or-zero word lines, zero when not pulsing.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (!$onehot0(if_a.wwl) || !$onehot0(if_b.wwl) ||
             (if_a.done && if_a.wwl != 8'h00) || (!if_a.busy && if_a.wwl != 8'h00) ||
             (if_b.done && if_b.wwl != 8'h00) || (!if_b.busy && if_b.wwl != 8'h00)) begin
            errors++;
            $display("FAIL invariant: wwl_a=%b wwl_b=%b at %0t", if_a.wwl, if_b.wwl, $time);
         end
      end
   end

   initial begin
      vecs[0] = '{3'd0, 8'b0000_0001};
      vecs[1] = '{3'd1, 8'b0000_0010};
      vecs[2] = '{3'd2, 8'b0000_0100};
      vecs[3] = '{3'd3, 8'b0000_1000};
      vecs[4] = '{3'd4, 8'b0001_0000};
      vecs[5] = '{3'd5, 8'b0010_0000};
      vecs[6] = '{3'd6, 8'b0100_0000};
      vecs[7] = '{3'd7, 8'b1000_0000};

      if_a.req_valid = 1'b0; if_a.req_addr = 3'd0;
      if_b.req_valid = 1'b0; if_b.req_addr = 3'd0;

      // Reset state
      rst = 1'b1;
      edge1(); edge1();
      chk("rst_wwl",   if_a.wwl, 8'h00);
      chk("rst_busy",  if_a.busy, 1'b0);
      chk("rst_done",  if_a.done, 1'b0);
      chk("rst_ready", if_a.req_ready, 1'b0);

      // Basic pulse at addr 0
      @(negedge clk);
      rst = 1'b0;
      if_a.req_valid = 1'b1; if_a.req_addr = 3'd0;
      #1;
      chk("rel_ready", if_a.req_ready, 1'b1);
      edge1();
      if_a.req_valid = 1'b0;
      chk("p0_wwl_c2",  if_a.wwl, 8'b0000_0001);
      chk("p0_busy_c2", if_a.busy, 1'b1);
      chk("p0_rdy_c2",  if_a.req_ready, 1'b0);
      chk("p0_done_c2", if_a.done, 1'b0);
      edge1();
      chk("p0_wwl_c3",  if_a.wwl, 8'b0000_0001);
      edge1();
      chk("p0_wwl_c4",  if_a.wwl, 8'h00);
      chk("p0_done_c4", if_a.done, 1'b1);
      chk("p0_busy_c4", if_a.busy, 1'b1);
      edge1();
      chk("p0_done_c5", if_a.done, 1'b0);
      chk("p0_busy_c5", if_a.busy, 1'b0);
      chk("p0_rdy_c5",  if_a.req_ready, 1'b1);

      // Sweep all addresses
      for (int i = 0; i < 8; i++) begin
         if_a.req_valid = 1'b1; if_a.req_addr = vecs[i].addr;
         edge1();
         if_a.req_valid = 1'b0; if_a.req_addr = 3'd0;
         chk("sweep_wwl1", if_a.wwl, vecs[i].exp_wwl);
         edge1();
         chk("sweep_wwl2", if_a.wwl, vecs[i].exp_wwl);
         edge1();
         chk("sweep_gap",  {if_a.done, if_a.wwl}, {1'b1, 8'h00});
         edge1();
         chk("sweep_idle", if_a.req_ready, 1'b1);
      end

`ifndef WWL_QUEUE_EN
      // Held request while busy is deferred, and addr sampled only at acceptance
      if_a.req_valid = 1'b1; if_a.req_addr = 3'd6;
      edge1();
      if_a.req_addr = 3'd1;
      chk("b2b_a_c1", if_a.wwl, 8'b0100_0000);
      edge1();
      chk("b2b_a_c2", if_a.wwl, 8'b0100_0000);
      edge1();
      chk("b2b_gap",  {if_a.done, if_a.wwl}, {1'b1, 8'h00});
      edge1();
      chk("b2b_idle", {if_a.busy, if_a.req_ready, if_a.wwl}, {1'b0, 1'b1, 8'h00});
      edge1();
      if_a.req_valid = 1'b0;
      chk("b2b_b_c1", if_a.wwl, 8'b0000_0010);
      edge1();
      chk("b2b_b_c2", if_a.wwl, 8'b0000_0010);
      edge1();
      chk("b2b_b_gap", {if_a.done, if_a.wwl}, {1'b1, 8'h00});
      edge1();
`else
      // Request buffered during PULSE chains directly after the gap
      if_a.req_valid = 1'b1; if_a.req_addr = 3'd4;
      edge1();
      if_a.req_addr = 3'd2;
      chk("q_a_c1", if_a.wwl, 8'b0001_0000);
      chk("q_rdy",  if_a.req_ready, 1'b1);
      edge1();
      if_a.req_valid = 1'b0;
      chk("q_a_c2", if_a.wwl, 8'b0001_0000);
      edge1();
      chk("q_gap1", {if_a.busy, if_a.done, if_a.wwl}, {1'b1, 1'b1, 8'h00});
      edge1();
      chk("q_b_c1", {if_a.busy, if_a.wwl}, {1'b1, 8'b0000_0100});
      edge1();
      chk("q_b_c2", {if_a.busy, if_a.wwl}, {1'b1, 8'b0000_0100});
      edge1();
      chk("q_gap2", {if_a.busy, if_a.done, if_a.wwl}, {1'b1, 1'b1, 8'h00});
      edge1();
      chk("q_idle", if_a.busy, 1'b0);
`endif

      // Asynchronous reset mid-pulse
      if_a.req_valid = 1'b1; if_a.req_addr = 3'd7;
      edge1();
      if_a.req_valid = 1'b0;
      chk("ar_wwl_pre", if_a.wwl, 8'b1000_0000);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_wwl_async", if_a.wwl, 8'h00);
      chk("ar_busy",      if_a.busy, 1'b0);
      chk("ar_ready",     if_a.req_ready, 1'b0);
      edge1();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ar_ready_rel", if_a.req_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         edge1();
         chk("ar_no_done", {if_a.done, if_a.busy, if_a.wwl}, {1'b0, 1'b0, 8'h00});
      end

      // Short pulse, long gap on the second instance
      if_b.req_valid = 1'b1; if_b.req_addr = 3'd5;
      edge1();
      if_b.req_valid = 1'b0;
      chk("pg_wwl",    if_b.wwl, 8'b0010_0000);
      edge1();
      chk("pg_gap1",   {if_b.busy, if_b.done, if_b.wwl}, {1'b1, 1'b1, 8'h00});
      edge1();
      chk("pg_gap2",   {if_b.busy, if_b.done, if_b.wwl}, {1'b1, 1'b0, 8'h00});
      edge1();
      chk("pg_gap3",   {if_b.busy, if_b.done, if_b.wwl}, {1'b1, 1'b0, 8'h00});
      chk("pg_rdy_g3", if_b.req_ready, 1'b0);
      edge1();
      chk("pg_idle",   {if_b.busy, if_b.req_ready}, {1'b0, 1'b1});

      edge1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
